control_pipeline: RTL and testbench



---
 rtl/control_pipeline_pkg.sv | 32 +++
 rtl/control_pipeline_stage_reg.sv | 43 ++++
 rtl/control_pipeline.sv | 110 +++++++++++
 tb/tb_control_pipeline.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/control_pipeline_pkg.sv
// Shared control-word types for the EX/MEM/WB control pipeline.
package control_pipeline_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9,
      ALU_PASS = 4'd10
   } alu_op_type;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      alu_op_type alu_op;
      logic       is_branch;
      logic       is_jump;
   } control_type;

   localparam control_type CONTROL_NOP = control_type'('0);
   localparam int unsigned REG_IDX_W   = 5;

endpackage

// File: rtl/control_pipeline_stage_reg.sv
// One pipeline stage register holding {control, valid, rd}; resets to a bubble.
module control_stage_reg
   import control_pipeline_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 bubble,
   input  control_type          d_control,
   input  logic                 d_valid,
   input  logic [REG_IDX_W-1:0] d_rd,
   output control_type          q_control,
   output logic                 q_valid,
   output logic [REG_IDX_W-1:0] q_rd
);

   control_type          r_control;
   logic                 r_valid;
   logic [REG_IDX_W-1:0] r_rd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_control <= CONTROL_NOP;
         r_valid   <= 1'b0;
         r_rd      <= '0;
      end else if (en) begin
         if (bubble) begin
            r_control <= CONTROL_NOP;
            r_valid   <= 1'b0;
            r_rd      <= '0;
         end else begin
            r_control <= d_control;
            r_valid   <= d_valid;
            r_rd      <= d_rd;
         end
      end
   end

   assign q_control = r_control;
   assign q_valid   = r_valid;
   assign q_rd      = r_rd;

endmodule

// File: rtl/control_pipeline.sv
// EX/MEM/WB control pipeline with load-use stall, branch flush, global hold
// and saturating stall/flush event counters.
module control_pipeline
   import control_pipeline_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  control_type          control_in,
   input  logic                 id_valid,
   input  logic [REG_IDX_W-1:0] rd_id,
   input  logic [REG_IDX_W-1:0] rs1_id,
   input  logic [REG_IDX_W-1:0] rs2_id,
   input  logic                 branch_taken_ex,
   input  logic                 hold,
   output control_type          control_ex,
   output control_type          control_mem,
   output control_type          control_wb,
   output logic                 valid_ex,
   output logic                 valid_mem,
   output logic                 valid_wb,
   output logic [REG_IDX_W-1:0] rd_ex,
   output logic [REG_IDX_W-1:0] rd_mem,
   output logic [REG_IDX_W-1:0] rd_wb,
   output logic                 stall_id,
   output logic                 flush_id,
   output logic [CNT_W-1:0]     stall_count,
   output logic [CNT_W-1:0]     flush_count
);

   logic              w_hazard;
   logic              w_flush;
   logic              w_load_stall;
   logic              w_advance;
   logic              w_ex_bubble;
   control_type       w_ex_control;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_flush_cnt;

   assign w_hazard = id_valid & valid_ex & control_ex.mem_read & (rd_ex != '0)
                   & ((rd_ex == rs1_id) | (rd_ex == rs2_id));

   // Priority: hold > branch flush > load-use hazard > normal advance.
   assign w_advance    = ~hold;
   assign w_flush      = ~hold & branch_taken_ex;
   assign w_load_stall = ~hold & ~branch_taken_ex & w_hazard;
   assign w_ex_bubble  = w_flush | w_load_stall;
   assign w_ex_control = id_valid ? control_in : CONTROL_NOP;

   assign stall_id = ~rst & (hold | w_load_stall);
   assign flush_id = ~rst & w_flush;

   control_stage_reg u_ex (
      .clk       (clk),
      .rst       (rst),
      .en        (w_advance),
      .bubble    (w_ex_bubble),
      .d_control (w_ex_control),
      .d_valid   (id_valid),
      .d_rd      (rd_id),
      .q_control (control_ex),
      .q_valid   (valid_ex),
      .q_rd      (rd_ex)
   );

   control_stage_reg u_mem (
      .clk       (clk),
      .rst       (rst),
      .en        (w_advance),
      .bubble    (1'b0),
      .d_control (control_ex),
      .d_valid   (valid_ex),
      .d_rd      (rd_ex),
      .q_control (control_mem),
      .q_valid   (valid_mem),
      .q_rd      (rd_mem)
   );

   control_stage_reg u_wb (
      .clk       (clk),
      .rst       (rst),
      .en        (w_advance),
      .bubble    (1'b0),
      .d_control (control_mem),
      .d_valid   (valid_mem),
      .d_rd      (rd_mem),
      .q_control (control_wb),
      .q_valid   (valid_wb),
      .q_rd      (rd_wb)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_flush && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
         if (w_load_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
      end
   end

   assign stall_count = r_stall_cnt;
   assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_control_pipeline.sv
// Scoreboard bench for control_pipeline: a behavioural stage model pushes
// expected snapshots; a negedge monitor pops and compares against the DUT.
module tb_control_pipeline;
   import control_pipeline_pkg::*;

   localparam int unsigned CW      = 4;
   localparam int unsigned CNT_MAX = (1 << CW) - 1;

   typedef struct packed {
      control_type c;
      logic        v;
      logic [4:0]  rd;
   } st_t;

   typedef struct packed {
      st_t           ex;
      st_t           mem;
      st_t           wb;
      logic          stall;
      logic          flush;
      logic [CW-1:0] scnt;
      logic [CW-1:0] fcnt;
   } rec_t;

   logic          clk;
   logic          rst;
   control_type   control_in;
   logic          id_valid;
   logic [4:0]    rd_id, rs1_id, rs2_id;
   logic          branch_taken_ex;
   logic          hold;
   control_type   control_ex, control_mem, control_wb;
   logic          valid_ex, valid_mem, valid_wb;
   logic [4:0]    rd_ex, rd_mem, rd_wb;
   logic          stall_id, flush_id;
   logic [CW-1:0] stall_count, flush_count;

   control_pipeline #(.CNT_W(CW)) dut (
      .clk             (clk),
      .rst             (rst),
      .control_in      (control_in),
      .id_valid        (id_valid),
      .rd_id           (rd_id),
      .rs1_id          (rs1_id),
      .rs2_id          (rs2_id),
      .branch_taken_ex (branch_taken_ex),
      .hold            (hold),
      .control_ex      (control_ex),
      .control_mem     (control_mem),
      .control_wb      (control_wb),
      .valid_ex        (valid_ex),
      .valid_mem       (valid_mem),
      .valid_wb        (valid_wb),
      .rd_ex           (rd_ex),
      .rd_mem          (rd_mem),
      .rd_wb           (rd_wb),
      .stall_id        (stall_id),
      .flush_id        (flush_id),
      .stall_count     (stall_count),
      .flush_count     (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   rec_t exp_q[$];

   // Reference state: pipeline contents as a 3-entry array, newest first.
   st_t         m[3];
   int unsigned ms, mf;
   st_t         BUB;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) m[i] = BUB;
      ms = 0;
      mf = 0;
   endtask

   task automatic cyc(input control_type c, input logic iv, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic br, input logic h, input logic r);
      rec_t e;
      logic haz;
      @(posedge clk);
      #2;
      control_in = c; id_valid = iv; rd_id = rd; rs1_id = r1; rs2_id = r2;
      branch_taken_ex = br; hold = h; rst = r;
      if (r) model_reset();
      haz = !r && iv && m[0].v && m[0].c.mem_read && (m[0].rd != 0)
            && ((m[0].rd == r1) || (m[0].rd == r2));
      e.ex = m[0]; e.mem = m[1]; e.wb = m[2];
      e.stall = !r && (h || (!br && haz));
      e.flush = !r && !h && br;
      e.scnt  = CW'(ms);
      e.fcnt  = CW'(mf);
      exp_q.push_back(e);
      if (!r && !h) begin
         if (br) mf = (mf == CNT_MAX) ? mf : mf + 1;
         else if (haz) ms = (ms == CNT_MAX) ? ms : ms + 1;
         m[2] = m[1];
         m[1] = m[0];
         if (br || haz) m[0] = BUB;
         else begin
            m[0].c  = iv ? c : CONTROL_NOP;
            m[0].v  = iv;
            m[0].rd = rd;
         end
      end
   endtask

   initial begin : monitor
      rec_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ex",    32'({control_ex, valid_ex, rd_ex}),    32'(e.ex));
            check("mem",   32'({control_mem, valid_mem, rd_mem}), 32'(e.mem));
            check("wb",    32'({control_wb, valid_wb, rd_wb}),    32'(e.wb));
            check("stall_id",    32'(stall_id),    32'(e.stall));
            check("flush_id",    32'(flush_id),    32'(e.flush));
            check("stall_count", 32'(stall_count), 32'(e.scnt));
            check("flush_count", 32'(flush_count), 32'(e.fcnt));
         end
      end
   end

   initial begin : driver
      control_type add_w, lw_w, rnd_c;
      logic [31:0] r32;
      BUB = '{c: CONTROL_NOP, v: 1'b0, rd: 5'd0};
      model_reset();
      add_w = CONTROL_NOP; add_w.reg_write = 1'b1; add_w.alu_op = ALU_ADD;
      lw_w  = CONTROL_NOP; lw_w.reg_write = 1'b1; lw_w.mem_read = 1'b1;
      lw_w.mem_to_reg = 1'b1; lw_w.alu_src = 1'b1;
      control_in = CONTROL_NOP; id_valid = 0; rd_id = 0; rs1_id = 0; rs2_id = 0;
      branch_taken_ex = 0; hold = 0; rst = 1;

      cyc(CONTROL_NOP, 0, 0, 0, 0, 0, 0, 1);
      cyc(CONTROL_NOP, 0, 0, 0, 0, 0, 0, 1);
      // straight flow: ADD rd=5
      cyc(add_w, 1, 5, 1, 2, 0, 0, 0);
      repeat (4) cyc(CONTROL_NOP, 0, 0, 0, 0, 0, 0, 0);
      // load-use: LW x3 then ADD rs1=x3 (held in ID for the stall cycle)
      cyc(lw_w, 1, 3, 1, 0, 0, 0, 0);
      cyc(add_w, 1, 6, 3, 4, 0, 0, 0);
      cyc(add_w, 1, 6, 3, 4, 0, 0, 0);
      repeat (3) cyc(CONTROL_NOP, 0, 0, 0, 0, 0, 0, 0);
      // zero register never hazards
      cyc(lw_w, 1, 0, 1, 0, 0, 0, 0);
      cyc(add_w, 1, 7, 0, 0, 0, 0, 0);
      repeat (3) cyc(CONTROL_NOP, 0, 0, 0, 0, 0, 0, 0);
      // flush and hazard together
      cyc(lw_w, 1, 3, 1, 0, 0, 0, 0);
      cyc(add_w, 1, 8, 3, 0, 1, 0, 0);
      repeat (2) cyc(CONTROL_NOP, 0, 0, 0, 0, 0, 0, 0);
      // hold over a pending flush
      cyc(add_w, 1, 9, 1, 2, 0, 0, 0);
      repeat (4) cyc(add_w, 1, 10, 1, 2, 1, 1, 0);
      cyc(add_w, 1, 10, 1, 2, 1, 0, 0);
      repeat (3) cyc(CONTROL_NOP, 0, 0, 0, 0, 0, 0, 0);
      // reset with three valid instructions in flight
      cyc(add_w, 1, 11, 0, 0, 0, 0, 0);
      cyc(lw_w,  1, 12, 0, 0, 0, 0, 0);
      cyc(add_w, 1, 13, 0, 0, 0, 0, 0);
      cyc(add_w, 1, 14, 0, 0, 0, 0, 1);
      cyc(CONTROL_NOP, 0, 0, 0, 0, 0, 0, 0);
      // counter saturation
      repeat (CNT_MAX + 3) cyc(add_w, 1, 1, 0, 0, 1, 0, 0);
      repeat (CNT_MAX + 3) begin
         cyc(lw_w, 1, 4, 0, 0, 0, 0, 0);
         cyc(add_w, 1, 5, 4, 0, 0, 0, 0);
      end
      cyc(CONTROL_NOP, 0, 0, 0, 0, 0, 0, 1);
      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         r32   = $urandom;
         rnd_c = control_type'(r32[$bits(control_type)-1:0]);
         cyc(rnd_c, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 99) == 0));
      end

      @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
